// File: rtl/multi_pulse_sync.sv
// Multi-channel asynchronous input synchronizer with glitch filter and edge-pulse output.
// Optional per-channel saturating event counters are enabled by MULTI_PULSE_SYNC_COUNT_EN.
module multi_pulse_sync #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1,
    parameter int EDGE_MODE   = 0,
    parameter int COUNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          async_i,
    output logic [NUM_CH-1:0]          level_o,
    output logic [NUM_CH-1:0]          pulse_o,
    input  logic [NUM_CH-1:0]          count_clr_i,
    output logic [NUM_CH*COUNT_W-1:0]  count_o
);

    localparam int FCNT_W = $clog2(FILTER_LEN) + 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam bit RISE_EN = (EDGE_MODE == 0) || (EDGE_MODE == 2);
    localparam bit FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] chain;
        logic [FCNT_W-1:0]      fcnt;
        logic                   level_q;
        logic                   pulse_q;
        logic                   synced;
        logic                   accept;

        assign synced = chain[SYNC_STAGES-1];
        assign accept = (synced != level_q) && (fcnt == FCNT_LAST);

        // chain[0] is the only flop that ever samples the asynchronous input
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], async_i[c]};
            end
        end

        // A new level must persist FILTER_LEN cycles; any reversion restarts the count
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fcnt    <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (synced == level_q) begin
                    fcnt <= '0;
                end else if (accept) begin
                    fcnt    <= '0;
                    level_q <= synced;
                    pulse_q <= synced ? RISE_EN : FALL_EN;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end

        assign level_o[c] = level_q;
        assign pulse_o[c] = pulse_q;

`ifdef MULTI_PULSE_SYNC_COUNT_EN
        logic [COUNT_W-1:0] cnt;

        // Clear wins over increment but a coincident pulse is still counted
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (count_clr_i[c]) begin
                cnt <= COUNT_W'(pulse_q);
            end else if (pulse_q && !(&cnt)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign count_o[c*COUNT_W +: COUNT_W] = cnt;
`else
        assign count_o[c*COUNT_W +: COUNT_W] = '0;
`endif
    end

`ifndef MULTI_PULSE_SYNC_COUNT_EN
    logic unused_count_clr;
    assign unused_count_clr = ^count_clr_i;
`endif

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Randomized and directed bench for multi_pulse_sync; three parameter sets share one stimulus
// and are checked every cycle against a sample-history window model.
module tb_multi_pulse_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  async_i;
   logic [3:0]  count_clr_i;
   logic [3:0]  lev0, lev1, lev2;
   logic [3:0]  pul0, pul1, pul2;
   logic [31:0] cnt0, cnt1;
   logic [7:0]  cnt2;

   multi_pulse_sync #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_LEN(1), .EDGE_MODE(0), .COUNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .async_i(async_i), .level_o(lev0), .pulse_o(pul0),
      .count_clr_i(count_clr_i), .count_o(cnt0));
   multi_pulse_sync #(.NUM_CH(4), .SYNC_STAGES(3), .FILTER_LEN(3), .EDGE_MODE(2), .COUNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .async_i(async_i), .level_o(lev1), .pulse_o(pul1),
      .count_clr_i(count_clr_i), .count_o(cnt1));
   multi_pulse_sync #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_LEN(2), .EDGE_MODE(1), .COUNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .async_i(async_i), .level_o(lev2), .pulse_o(pul2),
      .count_clr_i(count_clr_i), .count_o(cnt2));

   int ssP[3] = '{2, 3, 2};
   int flP[3] = '{1, 3, 2};
   int emP[3] = '{0, 2, 1};
   int cwP[3] = '{8, 8, 2};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: inputs sampled at every posedge since reset release; a level flips when the
   // last FILTER_LEN synced samples all disagree with it
   logic [3:0] hist[$];
   bit mLev[3][4];
   bit mPul[3][4];
   int mCnt[3][4];

   task automatic modelReset();
      hist.delete();
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 4; c++) begin
            mLev[d][c] = 1'b0;
            mPul[d][c] = 1'b0;
            mCnt[d][c] = 0;
         end
   endtask

   task automatic modelEdge();
      logic [3:0] clrNow;
      int t;
      clrNow = count_clr_i;
      hist.push_back(async_i);
      t = hist.size() - 1;
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 4; c++) begin
            bit flip;
            int maxCnt;
            flip = 1'b1;
            for (int j = 0; j < flP[d]; j++) begin
               int n;
               bit s;
               n = t - ssP[d] - j;
               s = (n < 0) ? 1'b0 : hist[n][c];
               if (s == mLev[d][c]) flip = 1'b0;
            end
            maxCnt = (1 << cwP[d]) - 1;
            if (clrNow[c]) mCnt[d][c] = mPul[d][c] ? 1 : 0;
            else if (mPul[d][c] && mCnt[d][c] != maxCnt) mCnt[d][c] = mCnt[d][c] + 1;
            if (flip) begin
               mLev[d][c] = ~mLev[d][c];
               mPul[d][c] = mLev[d][c] ? (emP[d] != 1) : (emP[d] != 0);
            end else begin
               mPul[d][c] = 1'b0;
            end
         end
   endtask

   function automatic logic [31:0] expVec(int d, int kind);
      logic [31:0] v;
      v = '0;
      for (int c = 0; c < 4; c++) begin
         if (kind == 0) v[c] = mLev[d][c];
         else if (kind == 1) v[c] = mPul[d][c];
         else begin
`ifdef MULTI_PULSE_SYNC_COUNT_EN
            v = v | (32'(mCnt[d][c]) << (c * cwP[d]));
`endif
         end
      end
      return v;
   endfunction

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, observed, expected);
      end
   endtask

   task automatic checkAll();
      checkOutput("level0", {28'd0, lev0}, expVec(0, 0));
      checkOutput("pulse0", {28'd0, pul0}, expVec(0, 1));
      checkOutput("count0", cnt0, expVec(0, 2));
      checkOutput("level1", {28'd0, lev1}, expVec(1, 0));
      checkOutput("pulse1", {28'd0, pul1}, expVec(1, 1));
      checkOutput("count1", cnt1, expVec(1, 2));
      checkOutput("level2", {28'd0, lev2}, expVec(2, 0));
      checkOutput("pulse2", {28'd0, pul2}, expVec(2, 1));
      checkOutput("count2", {24'd0, cnt2}, expVec(2, 2));
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      cyc++;
      checkAll();
      @(negedge clk);
   endtask

   task automatic applyStimulus(logic [3:0] a, logic [3:0] clr, int n);
      async_i     = a;
      count_clr_i = clr;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic doReset(int cycles);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkAll();
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         checkAll();
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b1;
      async_i     = '0;
      count_clr_i = '0;
      #2;
      doReset(2);

      // Single rising edge on channel 0, then release
      applyStimulus(4'b0001, 4'b0000, 6);
      applyStimulus(4'b0000, 4'b0000, 8);

      // Short glitch on channel 1, then a held level
      applyStimulus(4'b0010, 4'b0000, 2);
      applyStimulus(4'b0000, 4'b0000, 8);
      applyStimulus(4'b0010, 4'b0000, 6);
      applyStimulus(4'b0000, 4'b0000, 8);

      // Both edges on channel 2, ten cycles apart
      applyStimulus(4'b0100, 4'b0000, 10);
      applyStimulus(4'b0000, 4'b0000, 10);

      // All channels together
      applyStimulus(4'b1111, 4'b0000, 8);
      applyStimulus(4'b0000, 4'b0000, 8);

      // Reset in the middle of filtering while the input is held high
      applyStimulus(4'b0001, 4'b0000, 2);
      doReset(3);
      applyStimulus(4'b0001, 4'b0000, 8);
      applyStimulus(4'b0000, 4'b0000, 8);

      // Five slow edges on channel 3 saturate the narrow counter, then clear it
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1000, 4'b0000, 6);
         applyStimulus(4'b0000, 4'b0000, 6);
      end
      applyStimulus(4'b0000, 4'b1000, 1);
      applyStimulus(4'b0000, 4'b0000, 2);

      // Clear issued exactly while channel 1 of the falling-edge instance is pulsing
      for (int k = 0; k < 72; k++) begin
         async_i        = ((k / 6) % 2 == 1) ? 4'b0010 : 4'b0000;
         count_clr_i    = '0;
         count_clr_i[1] = mPul[2][1];
         tick();
      end
      applyStimulus(4'b0000, 4'b0000, 6);

      // Random toggling, glitches and clears with a reset partway through
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 5) == 0) async_i[c] = ~async_i[c];
            count_clr_i[c] = ($urandom_range(0, 9) == 0);
         end
         if (k == 300) doReset(1);
         tick();
      end
      applyStimulus(4'b0000, 4'b0000, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
